// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> scoreboard bundle: issue/source info in,
// stall/busy/perf status out.
interface hazard_scoreboard_if #(
  parameter int AW  = 5,
  parameter int NRD = 2,
  parameter int CW  = 2,
  parameter int PCW = 16
);
  logic              issue_valid;
  logic              issue_we;
  logic [AW-1:0]     issue_rd;
  logic [CW-1:0]     issue_lat_i;
  logic [NRD-1:0]    rs_en;
  logic [NRD*AW-1:0] rs_idx;
  logic              flush_i;
  logic              stall_o;
  logic [NRD-1:0]    stall_port_o;
  logic              busy_o;
  logic [PCW-1:0]    stall_cnt_o;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat_i,
    output rs_en, rs_idx, flush_i,
    input  stall_o, stall_port_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat_i,
    input  rs_en, rs_idx, flush_i,
    output stall_o, stall_port_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard beside ID: each writer
// loads a wait count, readers of pending registers stall.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int NRD    = 2,
  parameter int CW     = 2,
  parameter int FWD_EN = 1,
  parameter int WB_LAT = 3,
  parameter int PCW    = 16
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave sb
);

  if (WB_LAT < 0 || WB_LAT > (2**CW) - 1) begin : g_chk
    $error("WB_LAT does not fit in CW-bit wait counter");
  end

  localparam logic [CW-1:0] WB_L = CW'(WB_LAT);

  logic [CW-1:0]  cnt_q [1:NREG-1];
  logic [CW-1:0]  lat;
  logic [CW-1:0]  rd_cnt;
  logic [NRD-1:0] hz;
  logic           waw;
  logic           stall;
  logic           fire;
  logic           busy;
  logic [PCW-1:0] sc_q;

  assign lat = (FWD_EN != 0) ? sb.issue_lat_i : WB_L;

  // x0 is never tracked: loops start at r=1, so index 0 never hits
  always_comb begin
    hz     = '0;
    rd_cnt = '0;
    busy   = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (sb.rs_idx[i*AW +: AW] == AW'(r) && cnt_q[r] != '0)
          hz[i] = sb.issue_valid & sb.rs_en[i];
      end
    end
    for (int r = 1; r < NREG; r++) begin
      if (sb.issue_rd == AW'(r))
        rd_cnt = cnt_q[r];
      if (cnt_q[r] != '0)
        busy = 1'b1;
    end
  end

  assign waw = sb.issue_valid & sb.issue_we
             & (sb.issue_rd != '0) & (rd_cnt > lat);

  assign stall = ~sb.flush_i & ((|hz) | waw);

  assign fire = sb.issue_valid & ~stall & ~sb.flush_i
              & sb.issue_we & (sb.issue_rd != '0)
              & (lat != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++)
        cnt_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (fire && sb.issue_rd == AW'(r))
          cnt_q[r] <= lat;
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sc_q <= '0;
    else if (stall && !(&sc_q))
      sc_q <= sc_q + 1'b1;
  end

  assign sb.stall_o      = stall;
  assign sb.stall_port_o = hz;
  assign sb.busy_o       = busy;
  assign sb.stall_cnt_o  = sc_q;

endmodule
